// File: rtl/id_remap_bits_checker.sv
// ID remapper: XORs an incoming ID with a programmable per-ID key behind a valid/ready
// register stage, and flags transfers whose asserted-bit population is out of range.
module id_remap_bits_checker #(
    parameter int WIDTH     = 4,
    parameter int MIN_BITS  = 1,
    parameter int MAX_BITS  = 2,
    parameter int ASSERTED  = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_id,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_id,
    input  logic                 chk_en,
    input  logic                 cfg_we,
    input  logic [WIDTH-1:0]     cfg_addr,
    input  logic [WIDTH-1:0]     cfg_data,
    output logic                 fire,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr
);

    localparam int Depth = 2 ** WIDTH;
    localparam logic [ERR_CNT_W-1:0] CntMax = '1;

    if (WIDTH < 1 || WIDTH > 8 || MIN_BITS < 0 || MIN_BITS > MAX_BITS || MAX_BITS > WIDTH)
    begin : g_param_err
        $error("id_remap_bits_checker: illegal WIDTH/MIN_BITS/MAX_BITS combination");
    end

    logic [WIDTH-1:0]     key_q [Depth];
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_id_q, out_id_d;
    logic                 fire_q;
    logic                 err_sticky_q, err_sticky_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 accept;
    logic                 xfer_chk;
    logic                 viol;
    logic [WIDTH-1:0]     chk_vec;
    int                   pop;

    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign xfer_chk = out_valid_q & out_ready & chk_en;

    always_comb begin
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        if (accept) begin
            out_valid_d = 1'b1;
            // key_q is read before this edge's cfg write lands, so a same-index write is unseen
            out_id_d    = in_id ^ key_q[in_id];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign chk_vec = (ASSERTED != 0) ? out_id_q : ~out_id_q;

    always_comb begin
        pop = 0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + int'(chk_vec[i]);
        end
    end

    assign viol = xfer_chk & ((pop < MIN_BITS) | (pop > MAX_BITS));

    // Clear is applied first so a coincident violation still registers as count 1.
    always_comb begin
        err_cnt_d    = err_clr ? '0 : err_cnt_q;
        err_sticky_d = err_clr ? 1'b0 : err_sticky_q;
        if (viol) begin
            err_sticky_d = 1'b1;
            if (err_cnt_d != CntMax) begin
                err_cnt_d = err_cnt_d + ERR_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q  <= 1'b0;
            out_id_q     <= '0;
            fire_q       <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_id_q     <= out_id_d;
            fire_q       <= viol;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < Depth; i++) begin
                key_q[i] <= WIDTH'(i + 1);
            end
        end else if (cfg_we) begin
            key_q[cfg_addr] <= cfg_data;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_id     = out_id_q;
    assign fire       = fire_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;

endmodule
